// File: rtl/rob_commit_if.sv
// Rename/execute/free-list side signals of the reorder buffer, bundled for rob_commit.
interface rob_commit_if #(
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7
) ();
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [PREG_W-1:0] alloc_pd_new;
  logic [PREG_W-1:0] alloc_pd_old;
  logic              alloc_is_ctrl;
  logic              cmpl_valid;
  logic [TAG_W-1:0]  cmpl_tag;
  logic              cmpl_mispredict;
  logic              write_en;
  logic [PREG_W-1:0] rob_data_in;
  logic              mispredict;
  logic [TAG_W:0]    count;

  modport master (
    output alloc_valid, alloc_tag, alloc_pd_new, alloc_pd_old, alloc_is_ctrl,
           cmpl_valid, cmpl_tag, cmpl_mispredict,
    input  alloc_ready, write_en, rob_data_in, mispredict, count
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_pd_new, alloc_pd_old, alloc_is_ctrl,
           cmpl_valid, cmpl_tag, cmpl_mispredict,
    output alloc_ready, write_en, rob_data_in, mispredict, count
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-wide commit, free-list return and flush on mispredict.
// Define ROB_CHECK_EN to add sticky protocol-error outputs err_tag / err_code.
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  rob_commit_if.slave rif
`ifdef ROB_CHECK_EN
  ,
  output logic        err_tag,
  output logic [1:0]  err_code
`endif
);
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [PREG_W-1:0] preg_t;

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
  localparam tag_t           ONE  = TAG_W'(1);

  logic [DEPTH-1:0]  valid_q, done_q, ctrl_q, mispred_q;
  preg_t [DEPTH-1:0] pd_new_q, pd_old_q;
  tag_t              head_q, tail_q;
  logic [TAG_W:0]    count_q, count_d;
  logic              wen_q, misp_q;
  preg_t             rdata_q;

  logic alloc_fire, cmpl_hit, commit, flush;

  assign rif.alloc_ready = (count_q != FULL) && !misp_q;
  assign rif.write_en    = wen_q;
  assign rif.rob_data_in = rdata_q;
  assign rif.mispredict  = misp_q;
  assign rif.count       = count_q;

  always_comb begin
    alloc_fire = rif.alloc_valid && rif.alloc_ready;
    cmpl_hit   = rif.cmpl_valid && valid_q[rif.cmpl_tag];
    commit     = valid_q[head_q] && done_q[head_q];
    flush      = commit && mispred_q[head_q];
    count_d    = count_q;
    if (flush)                    count_d = '0;
    else if (alloc_fire && !commit) count_d = count_q + 1'b1;
    else if (!alloc_fire && commit) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= '0;
      done_q    <= '0;
      ctrl_q    <= '0;
      mispred_q <= '0;
      pd_new_q  <= '0;
      pd_old_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wen_q     <= 1'b0;
      misp_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wen_q  <= 1'b0;
      misp_q <= 1'b0;
      if (cmpl_hit) begin
        done_q[rif.cmpl_tag]    <= 1'b1;
        mispred_q[rif.cmpl_tag] <= rif.cmpl_mispredict & ctrl_q[rif.cmpl_tag];
      end
      if (alloc_fire) begin
        valid_q[rif.alloc_tag]   <= 1'b1;
        done_q[rif.alloc_tag]    <= 1'b0;
        mispred_q[rif.alloc_tag] <= 1'b0;
        ctrl_q[rif.alloc_tag]    <= rif.alloc_is_ctrl;
        pd_new_q[rif.alloc_tag]  <= rif.alloc_pd_new;
        pd_old_q[rif.alloc_tag]  <= rif.alloc_pd_old;
        tail_q                   <= rif.alloc_tag + ONE;
      end
      if (commit) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + ONE;
        wen_q           <= |pd_old_q[head_q];
        rdata_q         <= pd_old_q[head_q];
      end
      // Flush wins over a same-cycle allocation; rename rolls back its own free list.
      if (flush) begin
        valid_q <= '0;
        tail_q  <= head_q + ONE;
        misp_q  <= 1'b1;
      end
      count_q <= count_d;
    end
  end

`ifdef ROB_CHECK_EN
  logic       err_q;
  logic [1:0] code_q, code_d;

  always_comb begin
    code_d = 2'd0;
    if (alloc_fire && rif.alloc_tag != tail_q)  code_d = 2'd1;
    else if (rif.cmpl_valid && !valid_q[rif.cmpl_tag]) code_d = 2'd2;
    else if (rif.cmpl_valid && done_q[rif.cmpl_tag])   code_d = 2'd3;
  end

  // First error is latched and held until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q  <= 1'b0;
      code_q <= 2'd0;
    end else if (!err_q && code_d != 2'd0) begin
      err_q  <= 1'b1;
      code_q <= code_d;
    end
  end

  assign err_tag  = err_q;
  assign err_code = code_q;
`endif
endmodule
